// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and register offsets for the interrupt arbiter
//
// Purpose: FSM state encoding, register-port offsets and the "no interrupt" ID
// shared by irq_gateway and irq_arbiter_ctrl.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ASSERT    = 2'd1,
        SERVICING = 2'd2
    } irq_state_t;

    localparam logic [4:0] IRQ_ENABLE_OFF   = 5'h00;
    localparam logic [4:0] IRQ_TRIGGER_OFF  = 5'h04;
    localparam logic [4:0] IRQ_PENDING_OFF  = 5'h08;
    localparam logic [4:0] IRQ_CLAIM_OFF    = 5'h0C;
    localparam logic [4:0] IRQ_COMPLETE_OFF = 5'h10;

    localparam int IRQ_ID_NONE = 0;

endpackage

// File: rtl/irq_gateway.sv
// rtl/irq_gateway.sv - per-source synchroniser, edge detect and pending flop
//
// Purpose: brings one asynchronous interrupt line into the clk domain and
// captures it into a pending bit, either on a rising edge or while the line
// is high (level mode).
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   src_irq     - raw asynchronous interrupt line
//   trigger     - 1 = rising-edge capture, 0 = level capture
//   in_service  - this source is being claimed or is in service (blocks level capture)
//   claim_clr   - this source is claimed this cycle (clears pending)
//   pending     - captured interrupt request
module irq_gateway
    import irq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic src_irq,
    input  logic trigger,
    input  logic in_service,
    input  logic claim_clr,
    output logic pending
);

    logic sync_meta;
    logic sync_q;
    logic prev_q;
    logic set_req;

    // A new edge wins over a simultaneous claim so that no edge is lost.
    // Level capture is suppressed while the source is claimed or in service,
    // otherwise a held line would immediately re-pend the interrupt being handled.
    always_comb begin
        set_req = 1'b0;
        if (trigger) begin
            set_req = sync_q & ~prev_q;
        end else begin
            set_req = sync_q & ~in_service;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            prev_q    <= 1'b0;
            pending   <= 1'b0;
        end else begin
            sync_meta <= src_irq;
            sync_q    <= sync_meta;
            prev_q    <= sync_q;
            pending   <= set_req | (pending & ~claim_clr);
        end
    end

endmodule

// File: rtl/irq_arbiter_ctrl.sv
// rtl/irq_arbiter_ctrl.sv - fixed-priority interrupt arbiter with claim/complete port
//
// Purpose: merges NUM_SRC interrupt lines into one registered request for the
// CSR unit. The core claims the highest-priority enabled pending source by
// reading CLAIM and finishes it by writing its ID to COMPLETE.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   src_irq     - raw asynchronous interrupt lines, bit 0 highest priority
//   bus_sel     - register access strobe, one cycle per access
//   bus_we      - 1 = write, 0 = read
//   bus_addr    - byte address within the block
//   bus_wdata   - write data
//   bus_rdata   - combinational read data, valid in the bus_sel cycle
//   irq_out     - registered interrupt request
//   irq_id      - candidate ID (ASSERT), in-service ID (SERVICING), else 0
module irq_arbiter_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_SRC-1:0]  src_irq,
    input  logic                bus_sel,
    input  logic                bus_we,
    input  logic [4:0]          bus_addr,
    input  logic [31:0]         bus_wdata,
    output logic [31:0]         bus_rdata,
    output logic                irq_out,
    output logic [ID_W-1:0]     irq_id
);

    irq_state_t          state;
    irq_state_t          state_next;

    logic [NUM_SRC-1:0]  enable_r;
    logic [NUM_SRC-1:0]  trigger_r;
    logic [NUM_SRC-1:0]  pending;
    logic [ID_W-1:0]     svc_id;

    logic                cand_valid;
    logic [ID_W-1:0]     cand_id;
    logic [NUM_SRC-1:0]  cand_onehot;

    logic                rd_en;
    logic                wr_en;
    logic                claim_fire;
    logic                complete_fire;
    logic [NUM_SRC-1:0]  claim_vec;
    logic [NUM_SRC-1:0]  in_service;

    logic                unused_wdata;
    assign unused_wdata = ^bus_wdata;

    // Priority encode: scanning downwards leaves the lowest index as winner.
    always_comb begin
        cand_valid  = 1'b0;
        cand_id     = ID_W'(IRQ_ID_NONE);
        cand_onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i] && enable_r[i]) begin
                cand_valid     = 1'b1;
                cand_id        = ID_W'(i + 1);
                cand_onehot    = '0;
                cand_onehot[i] = 1'b1;
            end
        end
    end

    // Reads are suppressed during reset so the port returns 0.
    assign rd_en = bus_sel & ~bus_we & ~reset;
    assign wr_en = bus_sel & bus_we;

    // A claim only has an effect while asserting a live candidate.
    assign claim_fire    = rd_en && (bus_addr == IRQ_CLAIM_OFF) &&
                           (state == ASSERT) && cand_valid;
    assign complete_fire = wr_en && (bus_addr == IRQ_COMPLETE_OFF) &&
                           (state == SERVICING) && (bus_wdata[ID_W-1:0] == svc_id);
    assign claim_vec     = claim_fire ? cand_onehot : '0;

    always_comb begin
        in_service = claim_vec;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((state == SERVICING) && (svc_id == ID_W'(i + 1))) begin
                in_service[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        irq_gateway u_gw (
            .clk        (clk),
            .reset      (reset),
            .src_irq    (src_irq[g]),
            .trigger    (trigger_r[g]),
            .in_service (in_service[g]),
            .claim_clr  (claim_vec[g]),
            .pending    (pending[g])
        );
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cand_valid) begin
                    state_next = ASSERT;
                end
            end
            ASSERT: begin
                if (!cand_valid) begin
                    state_next = IDLE;
                end else if (claim_fire) begin
                    state_next = SERVICING;
                end
            end
            SERVICING: begin
                if (complete_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            irq_out   <= 1'b0;
            svc_id    <= ID_W'(IRQ_ID_NONE);
            enable_r  <= '0;
            trigger_r <= '0;
        end else begin
            state   <= state_next;
            // irq_out is the registered image of the next state, so it rises
            // together with the move into ASSERT.
            irq_out <= (state_next == ASSERT);
            if (claim_fire) begin
                svc_id <= cand_id;
            end
            if (wr_en && (bus_addr == IRQ_ENABLE_OFF)) begin
                enable_r <= bus_wdata[NUM_SRC-1:0];
            end
            if (wr_en && (bus_addr == IRQ_TRIGGER_OFF)) begin
                trigger_r <= bus_wdata[NUM_SRC-1:0];
            end
        end
    end

    always_comb begin
        irq_id = ID_W'(IRQ_ID_NONE);
        case (state)
            ASSERT:    irq_id = cand_id;
            SERVICING: irq_id = svc_id;
            default:   irq_id = ID_W'(IRQ_ID_NONE);
        endcase
    end

    always_comb begin
        bus_rdata = 32'd0;
        if (rd_en) begin
            case (bus_addr)
                IRQ_ENABLE_OFF:  bus_rdata = 32'(enable_r);
                IRQ_TRIGGER_OFF: bus_rdata = 32'(trigger_r);
                IRQ_PENDING_OFF: bus_rdata = 32'(pending);
                IRQ_CLAIM_OFF:   bus_rdata = (state == ASSERT) ? 32'(cand_id) : 32'd0;
                default:         bus_rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter_ctrl.sv
// tb/tb_irq_arbiter_ctrl.sv - self-checking bench for irq_arbiter_ctrl
module tb_irq_arbiter_ctrl;

    localparam int NUM = 4;
    localparam int IDW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [NUM-1:0]  src_irq;
    logic            bus_sel;
    logic            bus_we;
    logic [4:0]      bus_addr;
    logic [31:0]     bus_wdata;
    logic [31:0]     bus_rdata;
    logic            irq_out;
    logic [IDW-1:0]  irq_id;

    always #5 clk = ~clk;

    irq_arbiter_ctrl #(.NUM_SRC(NUM), .ID_W(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_irq   (src_irq),
        .bus_sel   (bus_sel),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .irq_out   (irq_out),
        .irq_id    (irq_id)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: sources seen through a two-stage delay, pending set,
    // and a mode number 0 = quiet, 1 = requesting, 2 = in service.
    logic [NUM-1:0] m_s1 = '0, m_s2 = '0, m_prev = '0;
    logic [NUM-1:0] m_pend = '0, m_en = '0, m_trig = '0;
    int             m_mode = 0;
    int             m_svc  = 0;
    logic           m_irq  = 1'b0;

    function automatic int m_cand();
        for (int i = 0; i < NUM; i++)
            if (m_pend[i] && m_en[i]) return i + 1;
        return 0;
    endfunction

    function automatic int m_irq_id();
        if (m_mode == 1) return m_cand();
        if (m_mode == 2) return m_svc;
        return 0;
    endfunction

    function automatic logic [31:0] m_rdata();
        if (reset) return 32'd0;
        case (bus_addr)
            5'h00: return 32'(m_en);
            5'h04: return 32'(m_trig);
            5'h08: return 32'(m_pend);
            5'h0C: return (m_mode == 1) ? 32'(m_cand()) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_tick();
        int             cand;
        bit             claim, complete, rose, busy, set;
        int             nm;
        logic [NUM-1:0] np;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_prev = '0; m_pend = '0;
            m_en = '0; m_trig = '0; m_mode = 0; m_svc = 0; m_irq = 1'b0;
        end else begin
            cand     = m_cand();
            claim    = bus_sel && !bus_we && bus_addr == 5'h0C && m_mode == 1 && cand != 0;
            complete = bus_sel && bus_we && bus_addr == 5'h10 && m_mode == 2 &&
                       int'(bus_wdata[4:0]) == m_svc;
            for (int i = 0; i < NUM; i++) begin
                rose  = m_s2[i] && !m_prev[i];
                busy  = (m_mode == 2 && m_svc == i + 1) || (claim && cand == i + 1);
                set   = m_trig[i] ? rose : (m_s2[i] && !busy);
                np[i] = set || (m_pend[i] && !(claim && cand == i + 1));
            end
            nm = m_mode;
            if (m_mode == 0) begin
                if (cand != 0) nm = 1;
            end else if (m_mode == 1) begin
                if (cand == 0) nm = 0;
                else if (claim) begin nm = 2; m_svc = cand; end
            end else begin
                if (complete) nm = 0;
            end
            if (bus_sel && bus_we && bus_addr == 5'h00) m_en   = bus_wdata[NUM-1:0];
            if (bus_sel && bus_we && bus_addr == 5'h04) m_trig = bus_wdata[NUM-1:0];
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = src_irq;
            m_pend = np;
            m_mode = nm;
            m_irq  = (nm == 1);
        end
    endtask

    // One clock: compare against the model mid-cycle, then advance both.
    task automatic cycle();
        @(negedge clk);
        check("irq_out", irq_out, m_irq);
        check("irq_id", irq_id, m_irq_id());
        if (bus_sel && !bus_we) check("rdata", bus_rdata, m_rdata());
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic idle_bus();
        bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
        cycle();
        idle_bus();
    endtask

    task automatic read_expect(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = addr; bus_wdata = '0;
        #1;
        check(tag, bus_rdata, exp);
        cycle();
        idle_bus();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    int op;

    initial begin
        reset = 1'b1;
        src_irq = '0;
        idle_bus();
        @(posedge clk);
        model_tick();
        #1;
        reset = 1'b0;

        check("rst_irq_out", irq_out, 1'b0);
        check("rst_irq_id", irq_id, 0);
        read_expect(5'h00, 0, "rst_enable");
        read_expect(5'h08, 0, "rst_pending");

        // Level source 2
        bus_write(5'h00, 32'h4);
        bus_write(5'h04, 32'h0);
        src_irq = 4'b0100;
        wait_cycles(3);
        read_expect(5'h08, 32'h4, "s1_pending");
        check("s1_irq_out", irq_out, 1'b1);
        check("s1_irq_id", irq_id, 3);
        read_expect(5'h0C, 3, "s1_claim");
        check("s1_irq_drop", irq_out, 1'b0);
        wait_cycles(4);
        check("s1_no_reassert", irq_out, 1'b0);
        read_expect(5'h08, 0, "s1_pend_blocked");
        bus_write(5'h10, 3);
        check("s1_cpl_0", irq_out, 1'b0);
        wait_cycles(1);
        check("s1_cpl_1", irq_out, 1'b0);
        wait_cycles(1);
        check("s1_reassert", irq_out, 1'b1);
        check("s1_reassert_id", irq_id, 3);
        read_expect(5'h0C, 3, "s1_claim2");
        src_irq = '0;
        wait_cycles(3);
        bus_write(5'h10, 3);
        wait_cycles(3);
        check("s1_quiet", irq_out, 1'b0);

        // Priority between sources 1 and 3
        do_reset();
        bus_write(5'h00, 32'hA);
        src_irq = 4'b1010;
        wait_cycles(4);
        check("s2_cand", irq_id, 2);
        read_expect(5'h0C, 2, "s2_claim_hi");
        src_irq = 4'b1000;
        wait_cycles(3);
        bus_write(5'h10, 2);
        wait_cycles(2);
        check("s2_irq_out", irq_out, 1'b1);
        check("s2_next_id", irq_id, 4);
        read_expect(5'h0C, 4, "s2_claim_lo");
        src_irq = '0;
        wait_cycles(3);
        bus_write(5'h10, 4);

        // Edge source 0, second edge during service
        do_reset();
        bus_write(5'h00, 32'h1);
        bus_write(5'h04, 32'h1);
        src_irq = 4'b0001;
        wait_cycles(4);
        check("s3_irq_out", irq_out, 1'b1);
        read_expect(5'h0C, 1, "s3_claim");
        src_irq = '0;
        wait_cycles(3);
        src_irq = 4'b0001;
        wait_cycles(3);
        read_expect(5'h08, 32'h1, "s3_pend_retained");
        bus_write(5'h10, 1);
        wait_cycles(1);
        check("s3_reassert", irq_out, 1'b1);
        check("s3_reassert_id", irq_id, 1);

        // Claim and new edge in the same cycle
        src_irq = '0;
        wait_cycles(3);
        src_irq = 4'b0001;
        wait_cycles(2);
        read_expect(5'h0C, 1, "s4_claim");
        read_expect(5'h08, 32'h1, "s4_pend_kept");

        // Illegal accesses
        bus_write(5'h10, 2);
        check("s5_bad_cpl_out", irq_out, 1'b0);
        check("s5_bad_cpl_id", irq_id, 1);
        read_expect(5'h0C, 0, "s5_claim_svc");
        check("s5_still_svc", irq_id, 1);
        bus_write(5'h10, 1);
        wait_cycles(1);
        check("s5_assert", irq_out, 1'b1);
        bus_write(5'h00, 32'h0);
        wait_cycles(1);
        check("s5_disable_drop", irq_out, 1'b0);
        read_expect(5'h08, 32'h1, "s5_pend_disabled");
        read_expect(5'h0C, 0, "s5_claim_idle");

        // Reset while servicing with everything pending
        src_irq = '0;
        bus_write(5'h00, 32'hF);
        bus_write(5'h04, 32'hF);
        wait_cycles(3);
        src_irq = 4'b1111;
        wait_cycles(4);
        read_expect(5'h0C, 1, "s6_claim");
        src_irq = 4'b1110;
        wait_cycles(3);
        src_irq = 4'b1111;
        wait_cycles(3);
        read_expect(5'h08, 32'hF, "s6_pend_full");
        src_irq = '0;
        do_reset();
        check("s6_irq_out", irq_out, 1'b0);
        check("s6_irq_id", irq_id, 0);
        read_expect(5'h08, 0, "s6_pending");
        read_expect(5'h00, 0, "s6_enable");
        read_expect(5'h04, 0, "s6_trigger");

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NUM; i++)
                if ($urandom_range(0, 7) == 0) src_irq[i] = ~src_irq[i];
            idle_bus();
            op = $urandom_range(0, 9);
            case (op)
                4: begin bus_sel = 1; bus_we = 0; bus_addr = 5'h0C; end
                5: begin
                    bus_sel = 1; bus_we = 1; bus_addr = 5'h10;
                    bus_wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : 32'(m_svc);
                end
                6: begin bus_sel = 1; bus_we = 1; bus_addr = 5'h00; bus_wdata = $urandom; end
                7: begin bus_sel = 1; bus_we = 1; bus_addr = 5'h04; bus_wdata = $urandom; end
                8: begin bus_sel = 1; bus_we = 0; bus_addr = 5'($urandom_range(0, 7) * 4); end
                9: begin
                    bus_sel = 1; bus_we = 1; bus_addr = 5'($urandom_range(0, 7) * 4);
                    bus_wdata = $urandom;
                end
                default: ;
            endcase
            cycle();
        end
        reset = 1'b0;
        idle_bus();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
